// File: rtl/if_fetch_pkg.sv
// Shared widths, constants, FSM encoding and small PC helpers for the fetch stage.
package if_fetch_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] NOP  = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_DROP  = 1'b1
    } if_state_t;

    // Source selected for the IF/ID register on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_MEM    = 2'd1,
        IFID_SKID   = 2'd2,
        IFID_BUBBLE = 2'd3
    } ifid_sel_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction/address holding register; clear beats load, load beats unload.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  unload,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_inst,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] addr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= NOP;
            addr  <= ZERO;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            addr  <= load_addr;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// RV32I fetch stage: owns the PC, handshakes with instruction memory and feeds decode
// through an IF/ID register backed by a one-entry skid buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic                  inst_valid_o
);

    if_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [ADDR_WIDTH-1:0] jump_tgt;
    ifid_sel_t             ifid_sel;
    logic                  accepted;

    logic                  skid_load, skid_unload, skid_clear;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_inst;
    logic [ADDR_WIDTH-1:0] skid_addr;

    if_skid_buf u_skid (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_inst (imem_rdata_i),
        .load_addr (pc_q),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .addr      (skid_addr)
    );

    // pc is frozen while in DROP, so it still names the abandoned request.
    assign imem_req_o  = rst_i && ((state_q == IF_DROP) || !skid_valid);
    assign imem_addr_o = pc_q;
    assign accepted    = imem_req_o && imem_ack_i;
    assign jump_tgt    = word_align(jump_addr_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        ifid_sel    = IFID_HOLD;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        unique case (state_q)
            IF_FETCH: begin
                if (jump_i) begin
                    ifid_sel   = IFID_BUBBLE;
                    skid_clear = 1'b1;
                    if (accepted || !imem_req_o) begin
                        pc_d = jump_tgt;
                    end else begin
                        target_d = jump_tgt;
                        state_d  = IF_DROP;
                    end
                end else if (accepted) begin
                    pc_d = next_pc(pc_q);
                    if (!stall_i || !inst_valid_o) begin
                        ifid_sel = IFID_MEM;
                    end else begin
                        skid_load = 1'b1;
                    end
                end else if (!stall_i && skid_valid) begin
                    ifid_sel    = IFID_SKID;
                    skid_unload = 1'b1;
                end else if (!stall_i) begin
                    ifid_sel = IFID_BUBBLE;
                end
            end

            IF_DROP: begin
                if (jump_i) begin
                    target_d   = jump_tgt;
                    ifid_sel   = IFID_BUBBLE;
                    skid_clear = 1'b1;
                end else if (!stall_i) begin
                    ifid_sel = IFID_BUBBLE;
                end
                // A jump landing in the ack cycle must still win over the older target.
                if (accepted) begin
                    pc_d    = jump_i ? jump_tgt : target_q;
                    state_d = IF_FETCH;
                end
            end

            default: state_d = IF_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IF_FETCH;
            pc_q         <= RESET_PC;
            target_q     <= ZERO;
            inst_o       <= NOP;
            inst_addr_o  <= ZERO;
            inst_valid_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            case (ifid_sel)
                IFID_MEM: begin
                    inst_o       <= imem_rdata_i;
                    inst_addr_o  <= pc_q;
                    inst_valid_o <= 1'b1;
                end
                IFID_SKID: begin
                    inst_o       <= skid_inst;
                    inst_addr_o  <= skid_addr;
                    inst_valid_o <= 1'b1;
                end
                IFID_BUBBLE: begin
                    inst_o       <= NOP;
                    inst_addr_o  <= ZERO;
                    inst_valid_o <= 1'b0;
                end
                default: begin
                    inst_o       <= inst_o;
                    inst_addr_o  <= inst_addr_o;
                    inst_valid_o <= inst_valid_o;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a program-order model predicts which PC decode must see next.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall;
    logic        jump;
    logic [31:0] jump_addr;
    logic        mem_en;
    int          lat;
    int          wait_cnt;

    logic        req, ack, valid;
    logic [31:0] addr, rdata, inst, inst_addr;

    logic        req2, valid2;
    logic [31:0] addr2, rdata2, inst2, inst_addr2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: acknowledges once a request has waited 'lat' cycles.
    assign ack    = req && mem_en && (wait_cnt >= lat);
    assign rdata  = memfn(addr);
    assign rdata2 = memfn(addr2);

    always @(posedge clk) begin
        if (!rst_i || !req || ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall), .jump_i(jump), .jump_addr_i(jump_addr),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .jump_i(1'b0), .jump_addr_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(req2), .imem_rdata_i(rdata2),
        .inst_o(inst2), .inst_addr_o(inst_addr2), .inst_valid_o(valid2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] exp_addr  = 32'h0;
    logic        started   = 1'b0;
    logic        rst_prev  = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] held_addr = 32'h0;
    logic        pend_prev = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          delivered = 0;

    always @(negedge clk) begin
        if (started) begin
            if (rst_prev) begin
                chk("m_rst_valid", 32'(valid), 32'h0);
                chk("m_rst_inst", inst, 32'h0000_0013);
            end else if (valid) begin
                chk("m_addr", inst_addr, exp_addr);
                chk("m_inst", inst, memfn(exp_addr));
            end else begin
                chk("m_bubble_inst", inst, 32'h0000_0013);
                chk("m_bubble_addr", inst_addr, 32'h0);
            end
            if (!rst_i) chk("m_req_in_rst", 32'(req), 32'h0);
            if (hold_prev) chk("m_stall_hold", inst_addr, held_addr);
            if (pend_prev && rst_i) chk("m_req_stable", addr, pend_addr);
            if (pend_prev && rst_i) chk("m_req_kept", 32'(req), 32'h1);
        end

        hold_prev = started && rst_i && stall && !jump && valid;
        held_addr = inst_addr;
        pend_prev = started && rst_i && req && !ack;
        pend_addr = addr;
        rst_prev  = !rst_i;

        if (!rst_i)                exp_addr = 32'h0;
        else if (jump)             exp_addr = jump_addr & 32'hFFFF_FFFC;
        else if (valid && !stall) begin
            exp_addr  = exp_addr + 32'h4;
            delivered++;
        end
        if (!rst_i) started = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = 32'h0;
        lat = 0; mem_en = 1'b1;

        step(); step(); peek();
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_iaddr", inst_addr, 32'h0);

        step(); rst_i = 1'b1; peek();                       // C1
        chk("first_req", 32'(req), 32'h1);
        chk("first_addr", addr, 32'h0);
        chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);

        step(); peek();                                     // C2
        chk("c2_valid", 32'(valid), 32'h1);
        chk("c2_iaddr", inst_addr, 32'h0);
        chk("c2_inst", inst, 32'hA5A5_0000);
        chk("wrap_second_addr", addr2, 32'h0);
        chk("wrap_iaddr", inst_addr2, 32'hFFFF_FFFC);

        step(); peek();                                     // C3
        chk("c3_iaddr", inst_addr, 32'h4);
        step(); stall = 1'b1; peek();                       // C4
        chk("c4_iaddr", inst_addr, 32'h8);
        step(); peek();                                     // C5
        chk("skid_full_req", 32'(req), 32'h0);
        chk("c5_iaddr", inst_addr, 32'h8);
        step();                                             // C6
        step(); stall = 1'b0; peek();                       // C7
        chk("c7_iaddr", inst_addr, 32'h8);
        step(); peek();                                     // C8
        chk("skid_out_iaddr", inst_addr, 32'hC);
        step(); jump = 1'b1; jump_addr = 32'h103; peek();   // C9
        chk("c9_iaddr", inst_addr, 32'h10);
        chk("c9_req_addr", addr, 32'h14);
        chk("c9_ack", 32'(ack), 32'h1);
        step(); jump = 1'b0; peek();                        // C10
        chk("jmp_bubble", 32'(valid), 32'h0);
        chk("jmp_req_addr", addr, 32'h100);
        step(); jump = 1'b1; jump_addr = 32'h20; peek();    // C11
        chk("jmp_iaddr", inst_addr, 32'h100);
        chk("jmp_inst", inst, 32'hA5A5_0100);

        step(); jump = 1'b0; lat = 3; peek();               // C12
        chk("slow_addr", addr, 32'h20);
        chk("slow_noack", 32'(ack), 32'h0);
        step(); jump = 1'b1; jump_addr = 32'h200; peek();   // C13
        step(); jump = 1'b0; peek();                        // C14
        chk("drop_req", 32'(req), 32'h1);
        chk("drop_addr", addr, 32'h20);
        step(); peek();                                     // C15
        chk("drop_ack", 32'(ack), 32'h1);
        step(); lat = 0; peek();                            // C16
        chk("drop_next_addr", addr, 32'h200);
        chk("drop_bubble", 32'(valid), 32'h0);
        step(); stall = 1'b1; peek();                       // C17
        chk("drop_iaddr", inst_addr, 32'h200);
        step(); peek();                                     // C18
        chk("skid_full_req2", 32'(req), 32'h0);
        step(); rst_i = 1'b0; peek();                       // C19
        step(); rst_i = 1'b1; stall = 1'b0; peek();         // C20
        chk("mid_rst_inst", inst, 32'h0000_0013);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_req", 32'(req), 32'h1);
        chk("mid_rst_addr", addr, 32'h0);
        step(); peek();                                     // C21
        chk("mid_rst_iaddr", inst_addr, 32'h0);

        // Mixed stalls, latencies and back-to-back redirects checked by the model.
        for (int i = 0; i < 300; i++) begin
            step();
            stall     = (i % 9) >= 6;
            lat       = (i / 20) % 4;
            jump      = ((i % 23) == 21) || ((i % 23) == 22);
            jump_addr = 32'h400 + 32'(i * 8) + 32'(i % 4);
        end
        step(); jump = 1'b0; stall = 1'b0; lat = 0;
        step(); step(); peek();
        chk("delivered_enough", 32'(delivered >= 30), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
